// File: rtl/int_controller.sv
// int_controller: four-source interrupt controller with a memory-mapped register
// window (CTRL, MASK, PENDING, CAUSE) and a request/service/done handshake.
// Build option: define INTC_ROUND_ROBIN_EN for round-robin arbitration;
// the default build uses fixed priority with source 0 (timer) highest.
module int_controller #(
   parameter int          NSRC = 4,
   parameter logic [31:0] BASE = 32'h40000020
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_src,
   input  logic            kernel_mode,
   input  logic            MemRd,
   input  logic            MemWr,
   input  logic [31:0]     Addr,
   input  logic [31:0]     WriteData,
   output logic [31:0]     ReadData,
   output logic            Interrupt,
   output logic [1:0]      irq_id
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE, DONE} state_t;

   state_t          state, state_n;
   logic            ctrl_en;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] edge_det;
   logic [NSRC-1:0] clr;
   logic [NSRC-1:0] elig;
   logic            armed;
   logic            cause_vld;
   logic [1:0]      cause_id;
   logic [1:0]      win_id;
   logic            take;
   logic            ack;
   logic            sel_ctrl, sel_mask, sel_pend, sel_cause;
   logic            unused_wdata;

   assign sel_ctrl  = (Addr == BASE);
   assign sel_mask  = (Addr == BASE + 32'd4);
   assign sel_pend  = (Addr == BASE + 32'd8);
   assign sel_cause = (Addr == BASE + 32'd12);

   // An ACK only counts while a service is in progress; elsewhere it is ignored.
   assign ack = MemWr && sel_cause && (state == SERVICE);

   // armed stays low for the first clock after reset so a line that is already
   // high when reset releases is captured as the old level, not as an edge.
   assign edge_det = irq_src & ~src_q & {NSRC{armed}};

   assign elig = pending & mask;

   // Software clears and the ACK clear are merged; a new edge still wins below.
   assign clr = ((MemWr && sel_pend) ? WriteData[NSRC-1:0] : '0)
              | (ack ? (NSRC'(1) << cause_id) : '0);

   assign unused_wdata = ^WriteData[31:NSRC];

   // Source sampling for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src_q <= '0;
         armed <= 1'b0;
      end else begin
         src_q <= irq_src;
         armed <= 1'b1;
      end
   end

   // Software-written configuration registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_en <= 1'b0;
         mask    <= '0;
      end else begin
         if (MemWr && sel_ctrl) ctrl_en <= WriteData[0];
         if (MemWr && sel_mask) mask <= WriteData[NSRC-1:0];
      end
   end

   // Pending bits latch edges regardless of MASK; a same-cycle set beats a clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pending <= '0;
      else        pending <= (pending & ~clr) | edge_det;
   end

   // CAUSE captures the winner on a new request and loses its valid bit on ACK.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cause_id  <= '0;
         cause_vld <= 1'b0;
      end else if (take) begin
         cause_id  <= win_id;
         cause_vld <= 1'b1;
      end else if (ack) begin
         cause_vld <= 1'b0;
      end
   end

`ifdef INTC_ROUND_ROBIN_EN
   logic [1:0] ptr;
   logic [1:0] idx;
   logic       found;

   // Round robin: first eligible source at or after the pointer, wrapping 3->0.
   always_comb begin
      win_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NSRC; i++) begin
         idx = ptr + 2'(i);
         if (!found && elig[idx]) begin
            win_id = idx;
            found  = 1'b1;
         end
      end
   end

   // The pointer moves past the source just granted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    ptr <= '0;
      else if (take) ptr <= win_id + 2'd1;
   end
`else
   // Fixed priority: the lowest eligible index wins.
   always_comb begin
      win_id = '0;
      for (int i = NSRC - 1; i >= 0; i--)
         if (elig[i]) win_id = 2'(i);
   end
`endif

   // Handshake state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Next state: no new request while the handler runs or before it returns.
   always_comb begin
      state_n = state;
      take    = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_en && (|elig) && !kernel_mode) begin
               state_n = REQ;
               take    = 1'b1;
            end
         end
         REQ:     state_n = SERVICE;
         SERVICE: if (ack) state_n = DONE;
         DONE:    if (!kernel_mode) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Registered request outputs, high only for the single cycle spent in REQ.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Interrupt <= 1'b0;
         irq_id    <= '0;
      end else begin
         Interrupt <= take;
         irq_id    <= take ? win_id : 2'd0;
      end
   end

   // Register read mux; anything unselected or unused reads as zero.
   always_comb begin
      ReadData = '0;
      if (MemRd) begin
         if (sel_ctrl)  ReadData = {31'b0, ctrl_en};
         if (sel_mask)  ReadData = {{(32-NSRC){1'b0}}, mask};
         if (sel_pend)  ReadData = {{(32-NSRC){1'b0}}, pending};
         if (sel_cause) ReadData = {cause_vld, 29'b0, cause_id};
      end
   end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 The block SHALL have parameter NSRC, default 4, meaning the number of interrupt sources (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter BASE, default 32'h40000020, meaning the base address of its register window.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; the block resets on negedge reset while low.
REQ-005 irq_src  input  4  source lines, one per source: [0] timer, [1] uart_send, [2] uart_recv, [3] spare.
REQ-006 kernel_mode  input  1  processor PC[31]; 1 while the handler executes.
REQ-007 MemRd  input  1  register read strobe.
REQ-008 MemWr  input  1  register write strobe.
REQ-009 Addr  input  32  byte address.
REQ-010 WriteData  input  32  write data.
REQ-011 ReadData  output  32  read data; combinational.
REQ-012 Interrupt  output  1  interrupt request to the processor.
REQ-013 irq_id  output  2  winning source index; valid while Interrupt=1.

Function
REQ-014 Register map SHALL be: BASE+0 CTRL, with [0] global enable; BASE+4 MASK[3:0]; BASE+8 PENDING[3:0], read, write-1-to-clear; BASE+C CAUSE, [1:0] id and [31] valid, where any write is ACK.
REQ-015 ReadData SHALL be 0 when MemRd=0 or Addr is outside BASE..BASE+C, and unused bits SHALL read 0.
REQ-016 A source SHALL set its PENDING bit on the cycle after it is sampled rising (irq_src=1, previous sample 0), regardless of MASK.
REQ-017 When a set and a write-1-to-clear hit the same bit in the same cycle, the set SHALL win.
REQ-018 The FSM SHALL have states IDLE, REQ, SERVICE and DONE.
REQ-019 IDLE SHALL go to REQ when CTRL[0]=1, (PENDING & MASK)!=0 and kernel_mode=0; on that transition the winner id is latched into CAUSE and CAUSE[31] is set.
REQ-020 In REQ, Interrupt SHALL be 1 for exactly one cycle, irq_id SHALL equal CAUSE[1:0], and the next state SHALL be SERVICE unconditionally.
REQ-021 SERVICE SHALL go to DONE on an ACK write; the ACK clears PENDING[CAUSE[1:0]] and CAUSE[31] in the same edge.
REQ-022 DONE SHALL go to IDLE when kernel_mode=0, so that no new request is made before the handler returns.
REQ-023 An ACK write outside SERVICE SHALL be ignored.
REQ-024 When kernel_mode=1 in IDLE, no request SHALL be made; pending sources SHALL be held.
REQ-025 Clearing MASK or CTRL[0] during SERVICE SHALL NOT abort the service; it affects only later arbitration.
REQ-026 Interrupt SHALL be a registered output (no glitches) and SHALL be 0 in every state except REQ.

Reset
REQ-027 While reset=0, state SHALL be IDLE, and PENDING, MASK, CTRL, CAUSE, the source sample register and the round-robin pointer SHALL be 0.
REQ-028 While reset=0, Interrupt and irq_id SHALL be 0, and ReadData SHALL follow REQ-015.
REQ-029 A reset asserted in any state, including REQ, SHALL drop Interrupt immediately and discard the service in progress.
REQ-030 After reset is released, a source already high SHALL NOT register as an edge until it goes low and then high again.

Configuration
REQ-031 Macro INTC_ROUND_ROBIN_EN SHALL select the arbitration scheme.
REQ-032 When INTC_ROUND_ROBIN_EN is defined, the winner SHALL be the first eligible source at or after the pointer, searching upward and wrapping 3->0; the pointer SHALL become winner+1 mod 4 on the IDLE->REQ edge.
REQ-033 When INTC_ROUND_ROBIN_EN is undefined, the winner SHALL be the lowest eligible index (fixed priority: timer highest), and the pointer logic SHALL be absent.

Verification
REQ-034 Reset, then write MASK=4'hF and CTRL=1, then pulse irq_src[0] high for 1 cycle -> PENDING=4'b0001 next cycle; Interrupt=1 for one cycle with irq_id=0 one cycle later; CAUSE reads 32'h80000000.
REQ-035 With kernel_mode=1 in SERVICE, write ACK -> PENDING[0]=0 and CAUSE[31]=0; Interrupt stays 0 until kernel_mode=0, and no second pulse occurs with no new edges.
REQ-036 Raise irq_src[2] and irq_src[0] in the same cycle -> fixed priority: ids 0 then 2; round robin with pointer=1: id 2 first, then 0 after ACK.
REQ-037 Set MASK=4'b0000 and pulse irq_src[1] -> PENDING=4'b0010 with no Interrupt; then write MASK=4'b0010 -> Interrupt with irq_id=1 within 2 cycles.
REQ-038 Write 1 to clear PENDING[3] in the same cycle irq_src[3] rises -> PENDING[3] reads 1.
REQ-039 Assert reset during REQ -> Interrupt=0 immediately; all registers read 0 after release.
